// File: rtl/dp_ir_reg.sv
// -----------------------------------------------------------------------------
// dp_ir_reg
// JTAG instruction register for the debug transport module. It contains the IR
// shift stage (sr_q), the update stage (ir_q) and a registered data-register
// select that steers the DR mux. The TAP controller supplies its state strobes.
// On any edge the first asserted strobe in this list wins:
//   tlr > capture_ir > shift_ir > update_ir > hold.
//
// Ports
//   tck         in   JTAG clock; all logic is rising-edge
//   trst        in   asynchronous active-high reset
//   tlr         in   TAP is in Test-Logic-Reset
//   capture_ir  in   TAP is in Capture-IR
//   shift_ir    in   TAP is in Shift-IR
//   update_ir   in   TAP is in Update-IR
//   tdi         in   serial data in
//   ir_tdo      out  serial data out (sr_q[0])
//   ir_q        out  current instruction (update stage)
//   bsr_sel     out  DR select: 0 BYPASS, 1 IDCODE, 2 DTMCS, 3 DMI
//   ir_upd      out  high for the cycle after each update-stage load
//   ir_err      out  sticky unknown-opcode flag; tlr or trst clears it
// -----------------------------------------------------------------------------
module dp_ir_reg #(
    parameter int unsigned IR_W        = 5,
    parameter int unsigned IDCODE_OP   = 'h01,
    parameter int unsigned DTMCS_OP    = 'h10,
    parameter int unsigned DMI_OP      = 'h11,
    parameter int unsigned RSV_LO      = 'h12,
    parameter int unsigned RSV_HI      = 'h17,
    parameter int unsigned CAPTURE_VAL = 'b00001,
    parameter bit          UNK_BYPASS  = 1'b1
) (
    input  logic            tck,
    input  logic            trst,
    input  logic            tlr,
    input  logic            capture_ir,
    input  logic            shift_ir,
    input  logic            update_ir,
    input  logic            tdi,
    output logic            ir_tdo,
    output logic [IR_W-1:0] ir_q,
    output logic [3:0]      bsr_sel,
    output logic            ir_upd,
    output logic            ir_err
);

    // DR mux select encoding shared with the DR mux
    localparam logic [3:0] SEL_BYPASS = 4'd0;
    localparam logic [3:0] SEL_IDCODE = 4'd1;
    localparam logic [3:0] SEL_DTMCS  = 4'd2;
    localparam logic [3:0] SEL_DMI    = 4'd3;

    localparam logic [IR_W-1:0] IDCODE_V  = IR_W'(IDCODE_OP);
    localparam logic [IR_W-1:0] DTMCS_V   = IR_W'(DTMCS_OP);
    localparam logic [IR_W-1:0] DMI_V     = IR_W'(DMI_OP);
    localparam logic [IR_W-1:0] RSV_LO_V  = IR_W'(RSV_LO);
    localparam logic [IR_W-1:0] RSV_HI_V  = IR_W'(RSV_HI);
    localparam logic [IR_W-1:0] CAPTURE_V = IR_W'(CAPTURE_VAL);

    logic [IR_W-1:0] sr_q, sr_d;
    logic [IR_W-1:0] ir_d;
    logic [3:0]      bsr_sel_q, bsr_sel_d;
    logic            ir_upd_q, ir_upd_d;
    logic            ir_err_q, ir_err_d;

    logic [3:0]      dec_sel;
    logic            dec_unk;

    // Single-level decode of the shift stage. Explicit opcodes are tested
    // first so they override the all-zeros/all-ones/reserved-range rules.
    always_comb begin
        dec_sel = SEL_BYPASS;
        dec_unk = 1'b0;
        if (sr_q == IDCODE_V) begin
            dec_sel = SEL_IDCODE;
        end else if (sr_q == DTMCS_V) begin
            dec_sel = SEL_DTMCS;
        end else if (sr_q == DMI_V) begin
            dec_sel = SEL_DMI;
        end else if ((sr_q == '0) || (sr_q == '1) ||
                     ((sr_q >= RSV_LO_V) && (sr_q <= RSV_HI_V))) begin
            dec_sel = SEL_BYPASS;
        end else begin
            dec_unk = 1'b1;
            dec_sel = UNK_BYPASS ? SEL_BYPASS : SEL_IDCODE;
        end
    end

    always_comb begin
        sr_d      = sr_q;
        ir_d      = ir_q;
        bsr_sel_d = bsr_sel_q;
        ir_err_d  = ir_err_q;
        ir_upd_d  = 1'b0;
        if (tlr) begin
            sr_d      = IDCODE_V;
            ir_d      = IDCODE_V;
            bsr_sel_d = SEL_IDCODE;
            ir_err_d  = 1'b0;
        end else if (capture_ir) begin
            sr_d = CAPTURE_V;
        end else if (shift_ir) begin
            // LSB-first: sr_q[0] leaves on ir_tdo, tdi enters at the top
            sr_d = {tdi, sr_q[IR_W-1:1]};
        end else if (update_ir) begin
            ir_d      = sr_q;
            bsr_sel_d = dec_sel;
            ir_upd_d  = 1'b1;
            if (dec_unk) begin
                ir_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            sr_q      <= IDCODE_V;
            ir_q      <= IDCODE_V;
            bsr_sel_q <= SEL_IDCODE;
            ir_upd_q  <= 1'b0;
            ir_err_q  <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            ir_q      <= ir_d;
            bsr_sel_q <= bsr_sel_d;
            ir_upd_q  <= ir_upd_d;
            ir_err_q  <= ir_err_d;
        end
    end

    assign ir_tdo  = sr_q[0];
    assign bsr_sel = bsr_sel_q;
    assign ir_upd  = ir_upd_q;
    assign ir_err  = ir_err_q;

endmodule

// File: tb/tb_dp_ir_reg.sv
`timescale 1ns/1ps
module tb_dp_ir_reg;

    localparam logic [3:0] SEL_BYPASS = 4'd0;
    localparam logic [3:0] SEL_IDCODE = 4'd1;
    localparam logic [3:0] SEL_DTMCS  = 4'd2;
    localparam logic [3:0] SEL_DMI    = 4'd3;

    logic tck = 1'b0;
    always #5 tck = ~tck;

    logic trst, tlr, cap, sh, upd, tdi;
    logic       ir_tdo, ir_upd, ir_err;
    logic [4:0] ir_q;
    logic [3:0] bsr_sel;
    logic       nb_tdo, nb_upd, nb_err;
    logic [4:0] nb_q;
    logic [3:0] nb_sel;
    logic       w_tlr = 0, w_cap = 0, w_sh = 0, w_upd = 0, w_tdi = 0;
    logic       w_tdo, w_upd_o, w_err;
    logic [7:0] w_q;
    logic [3:0] w_sel;

    dp_ir_reg dut (
        .tck(tck), .trst(trst), .tlr(tlr), .capture_ir(cap), .shift_ir(sh),
        .update_ir(upd), .tdi(tdi), .ir_tdo(ir_tdo), .ir_q(ir_q),
        .bsr_sel(bsr_sel), .ir_upd(ir_upd), .ir_err(ir_err));

    dp_ir_reg #(.UNK_BYPASS(1'b0)) dut_nb (
        .tck(tck), .trst(trst), .tlr(tlr), .capture_ir(cap), .shift_ir(sh),
        .update_ir(upd), .tdi(tdi), .ir_tdo(nb_tdo), .ir_q(nb_q),
        .bsr_sel(nb_sel), .ir_upd(nb_upd), .ir_err(nb_err));

    dp_ir_reg #(.IR_W(8), .DMI_OP('h22)) dut_w8 (
        .tck(tck), .trst(trst), .tlr(w_tlr), .capture_ir(w_cap), .shift_ir(w_sh),
        .update_ir(w_upd), .tdi(w_tdi), .ir_tdo(w_tdo), .ir_q(w_q),
        .bsr_sel(w_sel), .ir_upd(w_upd_o), .ir_err(w_err));

    int n_vec = 0;
    int n_err = 0;

    typedef struct { int ir; logic [3:0] sel; bit err; } exp_t;
    exp_t q_main[$];
    exp_t q_nb[$];

    // Reference model state (5-bit instances)
    int         m_sr, m_ir;
    logic [3:0] m_sel, m_sel_nb;
    bit         m_err, m_upd;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void ref_dec(input int w, input int x, input int dmi_op,
                                    input bit unkb, output logic [3:0] sel, output bit unk);
        int ones = (1 << w) - 1;
        unk = 0;
        if (x == 'h01)                                    sel = SEL_IDCODE;
        else if (x == 'h10)                               sel = SEL_DTMCS;
        else if (x == dmi_op)                             sel = SEL_DMI;
        else if (x == 0 || x == ones || (x >= 'h12 && x <= 'h17)) sel = SEL_BYPASS;
        else begin
            unk = 1;
            sel = unkb ? SEL_BYPASS : SEL_IDCODE;
        end
    endfunction

    function automatic void model_reset();
        m_sr = 1; m_ir = 1; m_sel = SEL_IDCODE; m_sel_nb = SEL_IDCODE;
        m_err = 0; m_upd = 0;
        q_main.delete();
        q_nb.delete();
    endfunction

    // One TAP cycle on the shared 5-bit instances; model follows the edge.
    task automatic step(input bit t, input bit c, input bit s, input bit u, input bit d);
        logic [3:0] sel, seln;
        bit unk, unkn;
        exp_t e;
        tlr = t; cap = c; sh = s; upd = u; tdi = d;
        @(posedge tck);
        if (t) begin
            m_sr = 1; m_ir = 1; m_sel = SEL_IDCODE; m_sel_nb = SEL_IDCODE;
            m_err = 0; m_upd = 0;
        end else if (c) begin
            m_sr = 1; m_upd = 0;
        end else if (s) begin
            m_sr = (m_sr >> 1) + (d ? 16 : 0); m_upd = 0;
        end else if (u) begin
            ref_dec(5, m_sr, 'h11, 1'b1, sel, unk);
            ref_dec(5, m_sr, 'h11, 1'b0, seln, unkn);
            m_ir = m_sr; m_sel = sel; m_sel_nb = seln;
            if (unk) m_err = 1;
            m_upd = 1;
            e.ir = m_ir; e.sel = sel;  e.err = m_err; q_main.push_back(e);
            e.sel = seln;                             q_nb.push_back(e);
        end else begin
            m_upd = 0;
        end
        #1;
    endtask

    task automatic scan(input int op);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, ((op >> i) & 1) != 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle, released after the next edge.
    task automatic do_trst();
        tlr = 0; cap = 0; sh = 0; upd = 0;
        #2;
        trst = 1;
        model_reset();
        @(posedge tck);
        #1;
        trst = 0;
    endtask

    // Monitor: continuous state compare plus scoreboard pop on each ir_upd.
    always @(negedge tck) begin
        exp_t e;
        check("tdo", ir_tdo, m_sr & 1);
        check("ir_q", ir_q, m_ir);
        check("bsr_sel", bsr_sel, m_sel);
        check("ir_err", ir_err, m_err);
        check("ir_upd", ir_upd, m_upd);
        check("nb_q", nb_q, m_ir);
        check("nb_sel", nb_sel, m_sel_nb);
        check("nb_err", nb_err, m_err);
        check("nb_tdo", nb_tdo, m_sr & 1);
        if (ir_upd === 1'b1) begin
            if (q_main.size() == 0) check("sb_main_empty", 1, 0);
            else begin
                e = q_main.pop_front();
                check("sb_ir_q", ir_q, e.ir);
                check("sb_sel", bsr_sel, e.sel);
                check("sb_err", ir_err, e.err);
            end
        end
        if (nb_upd === 1'b1) begin
            if (q_nb.size() == 0) check("sb_nb_empty", 1, 0);
            else begin
                e = q_nb.pop_front();
                check("sb_nb_sel", nb_sel, e.sel);
                check("sb_nb_err", nb_err, e.err);
            end
        end
    end

    // 8-bit instance: directed scans with direct checks.
    bit w_m_err = 0;
    task automatic w_step(input bit t, input bit c, input bit s, input bit u, input bit d);
        w_tlr = t; w_cap = c; w_sh = s; w_upd = u; w_tdi = d;
        @(posedge tck);
        #1;
    endtask

    task automatic w_scan(input int op);
        logic [3:0] sel;
        bit unk;
        w_step(0, 1, 0, 0, 0);
        check("w8_capture_tdo", w_tdo, 1);
        for (int i = 0; i < 8; i++) w_step(0, 0, 1, 0, ((op >> i) & 1) != 0);
        w_step(0, 0, 0, 1, 0);
        ref_dec(8, op, 'h22, 1'b1, sel, unk);
        if (unk) w_m_err = 1;
        check("w8_ir_q", w_q, op);
        check("w8_sel", w_sel, sel);
        check("w8_err", w_err, w_m_err);
        check("w8_upd", w_upd_o, 1);
        w_step(0, 0, 0, 0, 0);
        check("w8_upd_fall", w_upd_o, 0);
    endtask

    initial begin
        int r;
        trst = 1; tlr = 0; cap = 0; sh = 0; upd = 0; tdi = 0;
        model_reset();
        @(posedge tck);
        #1;
        trst = 0;
        step(0, 0, 0, 0, 0);

        // capture, shift 1,0,0,0,1 -> 'h11 / DMI
        scan('h11);

        // full decode sweep, each opcode from a clean TLR state
        for (int op = 0; op < 32; op++) begin
            step(1, 0, 0, 0, 0);
            scan(op);
        end

        // sticky error survives a valid update, clears on tlr
        step(1, 0, 0, 0, 0);
        scan('h05);
        scan('h10);
        step(1, 0, 0, 0, 0);

        // priority cases and held update
        scan('h10);
        step(1, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // trst and tlr in the middle of a shift
        scan('h11);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        do_trst();
        scan('h10);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // randomized scans, raw strobe mixes and resets
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r < 10) scan($urandom_range(0, 31));
            else if (r < 19) step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                  $urandom_range(0, 1) == 1);
            else do_trst();
        end
        step(0, 0, 0, 0, 0);

        // 8-bit instance with DMI_OP = 'h22
        w_step(1, 0, 0, 0, 0);
        check("w8_tlr_sel", w_sel, SEL_IDCODE);
        w_scan('h22);
        w_scan('h11);
        w_scan('hFF);
        w_step(1, 0, 0, 0, 0);
        w_m_err = 0;
        check("w8_tlr_err", w_err, 0);

        step(0, 0, 0, 0, 0);
        check("sb_main_drained", q_main.size(), 0);
        check("sb_nb_drained", q_nb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
